// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: default width, FSM states, counter sizing.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mult_pkg;

    localparam int N_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SIGNO = 2'd2
    } state_t;

    // One spare bit so the counter can hold N itself without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CNT_W_DEF = $clog2(N_DEF) + 1;

endpackage

// File: rtl/mult_secuencial_if.sv
// Start/operand/result bundle between a requester and the sequential multiplier.
// Latency: none, wiring only.
// Backpressure: none; the requester must watch Ocupado, because starts raised while busy are dropped.
interface mult_secuencial_if
    import mult_pkg::*;
#(
    parameter int N = N_DEF
);
    logic             Inicio;
    logic [N-1:0]     Datos_A;
    logic [N-1:0]     Datos_B;
    logic [2*N-1:0]   Datos_Sum;
    logic             Listo;
    logic             Ocupado;

    modport master (
        output Inicio, Datos_A, Datos_B,
        input  Datos_Sum, Listo, Ocupado
    );

    modport slave (
        input  Inicio, Datos_A, Datos_B,
        output Datos_Sum, Listo, Ocupado
    );
endinterface

// File: rtl/mult_secuencial_magnitud_signo.sv
// Splits a two's-complement word into an unsigned magnitude and a sign bit.
// Latency: combinational.
// Backpressure: not applicable.
module magnitud_signo #(
    parameter int N = 24
) (
    input  logic [N-1:0] dato,
    output logic [N-1:0] magnitud,
    output logic         signo
);
    // The most negative value negates to itself, which is already its correct unsigned magnitude.
    assign signo    = dato[N-1];
    assign magnitud = dato[N-1] ? (~dato + 1'b1) : dato;
endmodule

// File: rtl/mult_secuencial.sv
// Radix-2 shift-add signed multiplier: multiplies the magnitudes, then applies the sign, giving a 2N-bit product.
// Latency: N+2 edges from an accepted Inicio to the Listo pulse.
// Backpressure: Inicio is ignored while busy; the result is held until the next one replaces it.
module mult_secuencial
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    mult_secuencial_if.slave bus
);
    localparam int CW = cnt_w(N);

    state_t          state, next_state;
    logic [N-1:0]    mag_a, mag_b;
    logic            sgn_a, sgn_b;
    logic [N-1:0]    mcand, mplier;
    logic            sgn;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   cnt;

    magnitud_signo #(.N(N)) u_mag_a (
        .dato     (bus.Datos_A),
        .magnitud (mag_a),
        .signo    (sgn_a)
    );

    magnitud_signo #(.N(N)) u_mag_b (
        .dato     (bus.Datos_B),
        .magnitud (mag_b),
        .signo    (sgn_b)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Inicio) next_state = CALC;
            CALC:    if (cnt == CW'(N - 1)) next_state = SIGNO;
            SIGNO:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand         <= '0;
            mplier        <= '0;
            sgn           <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            bus.Datos_Sum <= '0;
            bus.Listo     <= 1'b0;
            bus.Ocupado   <= 1'b0;
        end else begin
            bus.Listo   <= 1'b0;
            // Busy stays up through the cycle that presents the result.
            bus.Ocupado <= (next_state != IDLE) || (state == SIGNO);
            case (state)
                IDLE: begin
                    if (bus.Inicio) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        sgn    <= sgn_a ^ sgn_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + ({{N{1'b0}}, mcand} << cnt);
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                SIGNO: begin
                    bus.Datos_Sum <= sgn ? -acc : acc;
                    bus.Listo     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_secuencial.sv
// Scoreboard bench for mult_secuencial: directed corners, busy/back-to-back/reset cases, random signed pairs.
module tb_mult_secuencial;
    import mult_pkg::*;

    localparam int N      = 24;
    localparam int N_RAND = 2000;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mult_secuencial_if #(.N(N)) bus ();

    mult_secuencial #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [2*N-1:0] sb_q[$];
    logic [2*N-1:0] mon_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    always @(posedge CLK) begin
        #1;
        if (bus.Listo === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("listo_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("datos_sum", 64'(bus.Datos_Sum), 64'(mon_exp));
            end
        end
    end

    // Entered at a negedge; leaves at the negedge after the (N+2)th posedge so a following call is back-to-back.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic push,
                      input logic [2*N-1:0] exp, input int inj, input logic [N-1:0] ia,
                      input logic [N-1:0] ib, input int rst_at,
                      output int lat, output int nlisto, output int nocu);
        bus.Inicio  = 1'b1;
        bus.Datos_A = a;
        bus.Datos_B = b;
        if (push) sb_q.push_back(exp);
        lat = 0; nlisto = 0; nocu = 0;
        for (int i = 1; i <= N + 2; i++) begin
            @(posedge CLK);
            #1;
            if (bus.Listo === 1'b1) begin
                nlisto++;
                lat = i;
            end
            if (bus.Ocupado === 1'b1) nocu++;
            if (rst_at > 0 && i == rst_at + 1) begin
                chk("rst_datos_sum", 64'(bus.Datos_Sum), 64'd0);
                chk("rst_ocupado", 64'(bus.Ocupado), 64'd0);
            end
            @(negedge CLK);
            bus.Inicio = (i == inj);
            if (i == inj) begin
                bus.Datos_A = ia;
                bus.Datos_B = ib;
            end
            RST = (i == rst_at);
        end
        bus.Inicio = 1'b0;
    endtask

    logic [N-1:0]   da [6];
    logic [N-1:0]   db [6];
    logic [2*N-1:0] de [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, nl, no;
        logic [N-1:0] ra, rb;

        da[0] = 24'd3;       db[0] = 24'd5;       de[0] = 48'h0000_0000_000F;
        da[1] = 24'hFFFFFF;  db[1] = 24'd1;       de[1] = 48'hFFFF_FFFF_FFFF;
        da[2] = 24'hFFFFF9;  db[2] = 24'hFFFFFA;  de[2] = 48'h0000_0000_002A;
        da[3] = 24'h800000;  db[3] = 24'h800000;  de[3] = 48'h4000_0000_0000;
        da[4] = 24'h800000;  db[4] = 24'h7FFFFF;  de[4] = 48'hC000_0080_0000;
        da[5] = 24'h000000;  db[5] = 24'h800000;  de[5] = 48'h0000_0000_0000;

        RST = 1'b1;
        bus.Inicio  = 1'b0;
        bus.Datos_A = '0;
        bus.Datos_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_datos_sum", 64'(bus.Datos_Sum), 64'd0);
        chk("reset_listo", 64'(bus.Listo), 64'd0);
        chk("reset_ocupado", 64'(bus.Ocupado), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            op(da[i], db[i], 1'b1, de[i], 0, '0, '0, 0, lat, nl, no);
            chk("dir_latency", 64'(lat), 64'(N + 2));
            chk("dir_listo_count", 64'(nl), 64'd1);
            chk("dir_ocupado_cycles", 64'(no), 64'(N + 2));
            @(posedge CLK);
            #1;
            chk("idle_ocupado", 64'(bus.Ocupado), 64'd0);
            chk("idle_listo", 64'(bus.Listo), 64'd0);
            chk("idle_hold", 64'(bus.Datos_Sum), 64'(de[i]));
            @(negedge CLK);
        end

        // Start ignored mid-CALC, then a start accepted right at the end of the Listo cycle.
        op(24'd2, 24'd3, 1'b1, 48'd6, 5, 24'd9, 24'd9, 0, lat, nl, no);
        chk("busy_listo_count", 64'(nl), 64'd1);
        chk("busy_latency", 64'(lat), 64'(N + 2));
        op(24'd9, 24'd9, 1'b1, 48'd81, 0, '0, '0, 0, lat, nl, no);
        chk("b2b_listo_count", 64'(nl), 64'd1);
        chk("b2b_latency", 64'(lat), 64'(N + 2));

        op(24'd2, 24'd3, 1'b0, '0, 0, '0, '0, 10, lat, nl, no);
        chk("abort_listo_count", 64'(nl), 64'd0);
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("abort_no_listo", 64'(bus.Listo), 64'd0);
        end
        @(negedge CLK);

        for (int r = 0; r < N_RAND; r++) begin
            ra = ($urandom_range(0, 7) == 0) ? 24'h800000 : N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 24'h800000 : N'($urandom);
            op(ra, rb, 1'b1, ref_prod(ra, rb), 0, '0, '0, 0, lat, nl, no);
            chk("rand_listo_count", 64'(nl), 64'd1);
        end

        repeat (2) @(posedge CLK);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
